micro_sequencer: RTL and testbench

MICRO_SEQUENCER -- requirements
Module: micro_sequencer

---
 rtl/micro_sequencer.sv | 156 +++++++++++++++
 tb/tb_micro_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: 64x24 writable control store, single-level call/return,
// loop counter and status-conditioned branching driving a 12-bit datapath control word.
module micro_sequencer (
    input  logic        SYSTEM_CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic [5:0]  START_ADDR,
    input  logic [5:0]  LOOP_COUNT,
    input  logic [4:0]  STATUS_BITS,
    input  logic        UCODE_WE,
    input  logic [5:0]  UCODE_ADDR,
    input  logic [23:0] UCODE_DATA,
    output logic [11:0] CONTROL_BITS,
    output logic        EIL_BAR,
    output logic        BUSY,
    output logic        DONE,
    output logic [5:0]  UPC
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [2:0] C_CONT = 3'd0;
    localparam logic [2:0] C_JMP  = 3'd1;
    localparam logic [2:0] C_JZ   = 3'd2;
    localparam logic [2:0] C_JC   = 3'd3;
    localparam logic [2:0] C_JV   = 3'd4;
    localparam logic [2:0] C_JFZ  = 3'd5;
    localparam logic [2:0] C_CALL = 3'd6;
    localparam logic [2:0] C_DJNZ = 3'd7;

    logic [23:0] r_store [0:63];
    logic [0:0]  r_state;
    logic [5:0]  r_upc;
    logic [5:0]  r_lcnt;
    logic [5:0]  r_ret;
    logic        r_done;

    logic [23:0] w_word;
    logic [11:0] w_ctrl;
    logic        w_eil;
    logic [2:0]  w_cond;
    logic [5:0]  w_target;
    logic        w_ret;
    logic        w_end;
    logic [5:0]  w_upc_inc;
    logic [5:0]  w_lcnt_dec;

    logic [0:0]  w_state_nxt;
    logic [5:0]  w_upc_nxt;
    logic [5:0]  w_lcnt_nxt;
    logic [5:0]  w_ret_nxt;
    logic        w_done_nxt;

    // C4 carry is reported by the datapath but no branch condition tests it.
    logic        w_unused_c4;
    assign w_unused_c4 = STATUS_BITS[0];

    function automatic logic status_taken(input logic [2:0] cond, input logic [4:0] status);
        logic taken;
        taken = 1'b0;
        case (cond)
            C_JZ:    taken = status[2];
            C_JC:    taken = status[1];
            C_JV:    taken = status[4];
            C_JFZ:   taken = status[3];
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

    assign w_word     = r_store[r_upc];
    assign w_ctrl     = w_word[11:0];
    assign w_eil      = w_word[12];
    assign w_cond     = w_word[15:13];
    assign w_target   = w_word[21:16];
    assign w_ret      = w_word[22];
    assign w_end      = w_word[23];
    assign w_upc_inc  = r_upc + 6'd1;
    assign w_lcnt_dec = r_lcnt - 6'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_upc_nxt   = r_upc;
        w_lcnt_nxt  = r_lcnt;
        w_ret_nxt   = r_ret;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (START) begin
                    w_state_nxt = S_RUN;
                    w_upc_nxt   = START_ADDR;
                    w_lcnt_nxt  = LOOP_COUNT;
                    w_ret_nxt   = 6'd0;
                end
            end
            default: begin
                // END outranks RET, which outranks the COND field.
                if (w_end) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end else if (w_ret) begin
                    w_upc_nxt = r_ret;
                end else begin
                    case (w_cond)
                        C_CONT: w_upc_nxt = w_upc_inc;
                        C_JMP:  w_upc_nxt = w_target;
                        C_CALL: begin
                            w_ret_nxt = w_upc_inc;
                            w_upc_nxt = w_target;
                        end
                        C_DJNZ: begin
                            if (r_lcnt != 6'd0) begin
                                w_lcnt_nxt = w_lcnt_dec;
                                w_upc_nxt  = (w_lcnt_dec != 6'd0) ? w_target : w_upc_inc;
                            end else begin
                                w_upc_nxt = w_upc_inc;
                            end
                        end
                        default: w_upc_nxt = status_taken(w_cond, STATUS_BITS) ? w_target : w_upc_inc;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge SYSTEM_CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= S_IDLE;
            r_upc   <= 6'd0;
            r_lcnt  <= 6'd0;
            r_ret   <= 6'd0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_upc   <= w_upc_nxt;
            r_lcnt  <= w_lcnt_nxt;
            r_ret   <= w_ret_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Control store survives reset; writes are locked out while a program runs.
    always_ff @(posedge SYSTEM_CLK) begin
        if (UCODE_WE && (r_state == S_IDLE)) begin
            r_store[UCODE_ADDR] <= UCODE_DATA;
        end
    end

    assign CONTROL_BITS = (r_state == S_RUN) ? w_ctrl : 12'd0;
    assign EIL_BAR      = (r_state == S_RUN) ? w_eil  : 1'b0;
    assign BUSY         = (r_state == S_RUN);
    assign DONE         = r_done;
    assign UPC          = r_upc;

endmodule

// File: tb/tb_micro_sequencer.sv
// Scoreboard bench for micro_sequencer: stimulus queues the expected per-cycle
// trace and completion address; a negedge monitor pops and compares.
module tb_micro_sequencer;

    localparam logic [2:0] C_CONT = 3'd0;
    localparam logic [2:0] C_JMP  = 3'd1;
    localparam logic [2:0] C_JZ   = 3'd2;
    localparam logic [2:0] C_CALL = 3'd6;
    localparam logic [2:0] C_DJNZ = 3'd7;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  start_addr;
    logic [5:0]  loop_count;
    logic [4:0]  status;
    logic        we;
    logic [5:0]  waddr;
    logic [23:0] wdata;
    logic [11:0] ctrl;
    logic        eil;
    logic        busy;
    logic        done;
    logic [5:0]  upc;

    typedef struct packed {
        logic [5:0]  upc;
        logic [11:0] ctrl;
        logic        eil;
    } exp_t;

    exp_t       exp_q[$];
    logic [5:0] done_q[$];
    exp_t       mon_e;
    logic [5:0] mon_d;
    int         checks = 0;
    int         errors = 0;
    bit         mon_en = 1'b0;

    always #5 clk = ~clk;

    micro_sequencer dut (
        .SYSTEM_CLK  (clk),
        .RESET       (rst),
        .START       (start),
        .START_ADDR  (start_addr),
        .LOOP_COUNT  (loop_count),
        .STATUS_BITS (status),
        .UCODE_WE    (we),
        .UCODE_ADDR  (waddr),
        .UCODE_DATA  (wdata),
        .CONTROL_BITS(ctrl),
        .EIL_BAR     (eil),
        .BUSY        (busy),
        .DONE        (done),
        .UPC         (upc)
    );

    function automatic logic [23:0] uw(input logic e, input logic r, input logic [5:0] tgt,
                                       input logic [2:0] cond, input logic ei, input logic [11:0] c);
        return {e, r, tgt, cond, ei, c};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push(input logic [5:0] u, input logic [11:0] c, input logic ei);
        exp_t e;
        e.upc  = u;
        e.ctrl = c;
        e.eil  = ei;
        exp_q.push_back(e);
    endtask

    // Monitor: every RUN cycle must match the next queued microword; DONE must match a queued completion.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (busy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_run_cycle: got upc %0d, expected no RUN cycle", upc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("run_upc", 32'(upc), 32'(mon_e.upc));
                    check("run_ctrl", 32'(ctrl), 32'(mon_e.ctrl));
                    check("run_eil", 32'(eil), 32'(mon_e.eil));
                end
            end else begin
                check("idle_outputs_zero", 32'({ctrl, eil}), 32'd0);
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got DONE at upc %0d, expected none", upc);
                end else begin
                    mon_d = done_q.pop_front();
                    check("done_upc", 32'(upc), 32'(mon_d));
                    check("done_not_busy", 32'(busy), 32'd0);
                end
            end
        end
    end

    task automatic write_word(input logic [5:0] a, input logic [23:0] d);
        waddr = a;
        wdata = d;
        we    = 1'b1;
        @(posedge clk); #1;
        we    = 1'b0;
    endtask

    task automatic start_prog(input logic [5:0] a, input logic [5:0] lc);
        start_addr = a;
        loop_count = lc;
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || done_q.size() != 0 || busy) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL %s_timeout: got %0d trace / %0d done entries pending, expected 0",
                     name, exp_q.size(), done_q.size());
            exp_q.delete();
            done_q.delete();
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start_addr = '0; loop_count = '0;
        status = '0; we = 1'b0; waddr = '0; wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_upc", 32'(upc), 32'd0);
        check("reset_ctrl", 32'(ctrl), 32'd0);
        check("reset_eil", 32'(eil), 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("idle_after_reset", 32'(busy), 32'd0);

        write_word(6'd0,  uw(1'b0, 1'b0, 6'd0,  C_CONT, 1'b0, 12'h001));
        write_word(6'd1,  uw(1'b0, 1'b0, 6'd0,  C_CONT, 1'b1, 12'h002));
        write_word(6'd2,  uw(1'b0, 1'b0, 6'd0,  C_CONT, 1'b0, 12'h003));
        write_word(6'd3,  uw(1'b1, 1'b1, 6'd0,  C_CONT, 1'b1, 12'h0AA));
        write_word(6'd5,  uw(1'b0, 1'b0, 6'd20, C_JZ,   1'b0, 12'h055));
        write_word(6'd6,  uw(1'b1, 1'b0, 6'd0,  C_CONT, 1'b0, 12'h060));
        write_word(6'd20, uw(1'b1, 1'b0, 6'd0,  C_CONT, 1'b0, 12'h120));
        write_word(6'd8,  uw(1'b0, 1'b0, 6'd40, C_CALL, 1'b0, 12'h080));
        write_word(6'd9,  uw(1'b1, 1'b0, 6'd0,  C_CONT, 1'b0, 12'h090));
        write_word(6'd40, uw(1'b0, 1'b1, 6'd33, C_JMP,  1'b1, 12'h400));
        write_word(6'd10, uw(1'b0, 1'b0, 6'd10, C_DJNZ, 1'b0, 12'h0A0));
        write_word(6'd11, uw(1'b1, 1'b0, 6'd0,  C_CONT, 1'b0, 12'h0B0));
        write_word(6'd12, uw(1'b0, 1'b0, 6'd12, C_JMP,  1'b0, 12'hC12));
        write_word(6'd63, uw(1'b0, 1'b0, 6'd0,  C_CONT, 1'b0, 12'h3F0));
        mon_en = 1'b1;

        // Straight line, START ignored mid-run, START accepted in the DONE cycle (JZ taken).
        status = 5'b00100;
        push(6'd0, 12'h001, 1'b0); push(6'd1, 12'h002, 1'b1);
        push(6'd2, 12'h003, 1'b0); push(6'd3, 12'h0AA, 1'b1);
        done_q.push_back(6'd3);
        push(6'd5, 12'h055, 1'b0); push(6'd20, 12'h120, 1'b0);
        done_q.push_back(6'd20);
        start_prog(6'd0, 6'd0);
        @(posedge clk); #1;
        start = 1'b1; start_addr = 6'd10;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b1; start_addr = 6'd5;
        @(posedge clk); #1;
        start = 1'b0;
        drain("straight_jz_taken");

        // JZ not taken while every other status bit is set.
        status = 5'b11011;
        push(6'd5, 12'h055, 1'b0); push(6'd6, 12'h060, 1'b0);
        done_q.push_back(6'd6);
        start_prog(6'd5, 6'd0);
        drain("jz_not_taken");

        // DJNZ with counts 3, 1 and 0.
        push(6'd10, 12'h0A0, 1'b0); push(6'd10, 12'h0A0, 1'b0);
        push(6'd10, 12'h0A0, 1'b0); push(6'd11, 12'h0B0, 1'b0);
        done_q.push_back(6'd11);
        start_prog(6'd10, 6'd3);
        drain("djnz_3");
        push(6'd10, 12'h0A0, 1'b0); push(6'd11, 12'h0B0, 1'b0);
        done_q.push_back(6'd11);
        start_prog(6'd10, 6'd1);
        drain("djnz_1");
        push(6'd10, 12'h0A0, 1'b0); push(6'd11, 12'h0B0, 1'b0);
        done_q.push_back(6'd11);
        start_prog(6'd10, 6'd0);
        drain("djnz_0");

        // Wrap 63 -> 0.
        push(6'd63, 12'h3F0, 1'b0); push(6'd0, 12'h001, 1'b0); push(6'd1, 12'h002, 1'b1);
        push(6'd2, 12'h003, 1'b0); push(6'd3, 12'h0AA, 1'b1);
        done_q.push_back(6'd3);
        start_prog(6'd63, 6'd0);
        drain("wrap");

        // CALL/RET: RET outranks the JMP coded in word 40.
        push(6'd8, 12'h080, 1'b0); push(6'd40, 12'h400, 1'b1); push(6'd9, 12'h090, 1'b0);
        done_q.push_back(6'd9);
        start_prog(6'd8, 6'd0);
        drain("call_ret");

        // START clears the return register, so RET at entry goes to 0.
        push(6'd40, 12'h400, 1'b1); push(6'd0, 12'h001, 1'b0); push(6'd1, 12'h002, 1'b1);
        push(6'd2, 12'h003, 1'b0); push(6'd3, 12'h0AA, 1'b1);
        done_q.push_back(6'd3);
        start_prog(6'd40, 6'd0);
        drain("ret_cleared");

        // Reset mid-program with a locked-out write in between.
        mon_en = 1'b0;
        start_prog(6'd12, 6'd0);
        @(posedge clk); #1;
        check("loop_upc", 32'(upc), 32'd12);
        check("loop_busy", 32'(busy), 32'd1);
        check("loop_ctrl", 32'(ctrl), 32'hC12);
        write_word(6'd3, uw(1'b0, 1'b0, 6'd0, C_CONT, 1'b0, 12'hBAD));
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_upc", 32'(upc), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_ctrl", 32'(ctrl), 32'd0);
        check("async_rst_eil", 32'(eil), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_idle", 32'(busy), 32'd0);
        check("post_rst_upc", 32'(upc), 32'd0);
        mon_en = 1'b1;
        push(6'd0, 12'h001, 1'b0); push(6'd1, 12'h002, 1'b1);
        push(6'd2, 12'h003, 1'b0); push(6'd3, 12'h0AA, 1'b1);
        done_q.push_back(6'd3);
        start_prog(6'd0, 6'd0);
        drain("write_lockout");

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
